// File: rtl/modexp_ctrl.sv
// modexp_ctrl: left-to-right square-and-multiply sequencer for base^exp mod modulus,
// issuing each modular product to an external multiplier over a req/ack handshake.
module modexp_ctrl #(
    parameter int W  = 64,
    parameter int EW = 64
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          start_i,
    input  logic [W-1:0]  base_i,
    input  logic [EW-1:0] exp_i,
    input  logic [W-1:0]  modulus_i,
    output logic          busy_o,
    output logic          done_o,
    output logic [W-1:0]  result_o,
    output logic          mm_req_o,
    output logic [W-1:0]  mm_a_o,
    output logic [W-1:0]  mm_b_o,
    output logic [W-1:0]  mm_n_o,
    input  logic          mm_ack_i,
    input  logic [W-1:0]  mm_p_i
);
    localparam int CW = $clog2(EW + 1);

    typedef enum logic [2:0] {IDLE, SCAN, SQR, MUL, FIN} state_e;

    state_e        state_q, state_d;
    logic [W-1:0]  acc_q, acc_d, base_q, base_d, mod_q, mod_d;
    logic [EW-1:0] exp_q, exp_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d, done_q, done_d, req_q, req_d;
    logic [W-1:0]  result_q, result_d, a_q, a_d, b_q, b_d;
    logic          ack;

    assign ack = mm_ack_i & req_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            base_q   <= '0;
            mod_q    <= '0;
            exp_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            req_q    <= 1'b0;
            result_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            base_q   <= base_d;
            mod_q    <= mod_d;
            exp_q    <= exp_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            req_q    <= req_d;
            result_q <= result_d;
            a_q      <= a_d;
            b_q      <= b_d;
        end
    end

    // The first product is always 1*base, so an unreduced base never leaks into the result.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        base_d  = base_q;
        mod_d   = mod_q;
        exp_d   = exp_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (start_i) begin
                base_d  = base_i;
                exp_d   = exp_i;
                mod_d   = modulus_i;
                cnt_d   = CW'(EW);
                acc_d   = modulus_i > W'(1) ? W'(1) : '0;
                state_d = modulus_i > W'(1) ? SCAN : FIN;
            end
            SCAN: begin
                if (exp_q == '0) state_d = FIN;
                else if (exp_q[EW-1]) state_d = MUL;
                else begin
                    exp_d = exp_q << 1;
                    cnt_d = cnt_q - CW'(1);
                end
            end
            MUL: if (ack) begin
                acc_d   = mm_p_i;
                exp_d   = exp_q << 1;
                cnt_d   = cnt_q - CW'(1);
                state_d = cnt_q == CW'(1) ? FIN : SQR;
            end
            SQR: if (ack) begin
                acc_d = mm_p_i;
                if (exp_q[EW-1]) state_d = MUL;
                else begin
                    exp_d   = exp_q << 1;
                    cnt_d   = cnt_q - CW'(1);
                    state_d = cnt_q == CW'(1) ? FIN : SQR;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_d   = state_d != IDLE;
        done_d   = state_d == FIN;
        req_d    = state_d == SQR || state_d == MUL;
        a_d      = acc_d;
        b_d      = state_d == MUL ? base_d : acc_d;
        result_d = done_d ? acc_d : result_q;
    end

    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign result_o = result_q;
    assign mm_req_o = req_q;
    assign mm_a_o   = a_q;
    assign mm_b_o   = b_q;
    assign mm_n_o   = mod_q;
endmodule

// File: doc/modexp_ctrl.md
# modexp_ctrl

Sequencer for the RSA modular-exponentiation datapath: computes `result = base^exp mod modulus` by left-to-right binary square-and-multiply. It issues each step to an external modular multiplier over a req/ack handshake. It sits between the RSA top level (operand/start/done) and the shared multiplier, and owns the accumulator and exponent scan.

## Interface
- `W`, default 64: operand/modulus/result width.
- `EW`, default 64: exponent width.

- `clk`  in  1: clock, rising edge.
- `rst`  in  1: reset, asynchronous, active-low.
- `start`  in  1: request a new exponentiation; sampled only in IDLE.
- `base`  in  W: base, latched on accepted start (may be ≥ modulus).
- `exp`  in  EW: exponent, latched on accepted start.
- `modulus`  in  W: modulus, latched on accepted start.
- `busy`  out  1: high from the cycle after start acceptance through the FIN cycle.
- `done`  out  1: one-cycle pulse in FIN.
- `result`  out  W: final value; held from FIN until the next accepted start.
- `mm_req`  out  1: multiplier request.
- `mm_a`, `mm_b`, `mm_n`  out  W: multiplier operands; `mm_n` = latched modulus.
- `mm_ack`  in  1: multiplier completion; valid only while `mm_req`=1.
- `mm_p`  in  W: multiplier product `(mm_a*mm_b) mod mm_n`, valid with `mm_ack`.

## Operation
- States: IDLE, SCAN, SQR, MUL, FIN.
- IDLE:
  - On `start`=1, latch operands, set acc=1, first=1, and go to SCAN.
  - If the latched modulus is ≤ 1, go directly to FIN with acc=0.
- SCAN: one cycle per leading zero bit. Each cycle:
  - If the exp register is 0 → FIN, with result = acc (1).
  - Else if exp[EW-1]=1 → MUL.
  - Else shift exp left by 1 and decrement the bit counter.
- MUL:
  - Drive `mm_req`=1, `mm_a`=acc, `mm_b`=base.
  - On ack: acc←`mm_p`, first←0, shift exp left, decrement the bit counter.
  - Then: counter=0 → FIN; else SQR.
- SQR:
  - Drive `mm_req`=1, `mm_a`=`mm_b`=acc.
  - On ack: acc←`mm_p`.
  - Then: current MSB=1 → MUL; else shift and decrement, with counter=0 → FIN, else SQR.
- The first multiply is always MUL(1·base), so the result is reduced even when base ≥ modulus. No squaring is issued while acc is the initial 1.
- Handshake count for bit length L and popcount k: k MUL + (L−1) SQR.
- FIN: `result`←acc, `done`=1, → IDLE.
- `start` while busy is ignored; in-flight operands are unaffected.

## Timing
- Reset values: `busy`=0, `done`=0, `result`=0, `mm_req`=0, `mm_a`=`mm_b`=`mm_n`=0; state IDLE.
- All outputs are registered.
- Handshake:
  - `mm_req` rises on the first cycle of SQR/MUL.
  - Operands stay stable while `mm_req`=1 and `mm_ack`=0.
  - The op completes at the rising edge where `mm_req`=1 and `mm_ack`=1; zero-wait ack (same cycle as `mm_req` rise) is legal.
  - Back-to-back ops keep `mm_req` high. New operands appear the cycle after ack, and each ack retires exactly one op.
  - `mm_ack` while `mm_req`=0 is ignored.
- Latency from start edge to `done`:
  - 1 cycle to enter SCAN, plus z scan cycles (z = leading zeros), plus Σ(1+A_i) over handshakes (A_i = ack wait), plus 1 (FIN).
  - `exp`=0: `done` is 2 cycles after start, with zero handshakes.
- Reset mid-operation: all state clears immediately and `mm_req` drops asynchronously. A late `mm_ack` after reset is ignored; the multiplier is expected to be reset alongside.
- Simultaneous `start` and `done`: `start` in the FIN cycle is ignored; it is accepted the next cycle (IDLE).

## Test plan
- base=4, exp=13, modulus=497, zero-wait multiplier → `result`=445; exactly 6 handshakes (3 MUL, 3 SQR) in order MUL,SQR,MUL,SQR,SQR,MUL; `done` one cycle.
- base=10, exp=3, modulus=7 (base ≥ modulus) → `result`=6; exp=0, modulus=7 → `result`=1, `done` 2 cycles after start, `mm_req` never high.
- modulus=1 and modulus=0, any base/exp → `result`=0, no handshakes.
- Multiplier with ack delayed 5 cycles per op → `mm_req` held, `mm_a`/`mm_b`/`mm_n` constant during each wait; base=4, exp=13, modulus=497 still gives 445 with latency increased by 30 cycles.
- Pulse `start` with new operands mid-run → ignored, original result delivered. Assert `rst`=0 mid-run → `busy`/`mm_req`/`done`/`result` = 0 immediately; after release, a fresh base=3, exp=5, modulus=7 run → 5.
- exp=1<<(EW−1), base=2, modulus=1000003 → 63 SQR + 1 MUL; `result` matches the reference model.
